// File: rtl/mips_fetch_pkg.sv
// ============================================================================
// Module   : mips_fetch_pkg
// Brief    : Shared MIPS definitions: fetch FSM encoding, instruction field
//            bit positions and common opcode/funct values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 26;
    localparam int c_RS_MSB     = 25;
    localparam int c_RS_LSB     = 21;
    localparam int c_RT_MSB     = 20;
    localparam int c_RT_LSB     = 16;
    localparam int c_RD_MSB     = 15;
    localparam int c_RD_LSB     = 11;
    localparam int c_IMM_MSB    = 15;
    localparam int c_IMM_LSB    = 0;
    localparam int c_FUNCT_MSB  = 5;
    localparam int c_FUNCT_LSB  = 0;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;
    localparam logic [5:0] c_FUNCT_JR   = 6'h08;
    localparam logic [5:0] c_FUNCT_ADD  = 6'h20;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module   : pc_reg
// Brief    : 32-bit program counter with load enable and synchronous
//            active-low reset to RESET_PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/mips_fetch.sv
// ============================================================================
// Module   : mips_fetch
// Brief    : MIPS instruction fetch stage: requests words from instruction
//            memory, holds one instruction for decode, handles redirects/halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    input  logic        except,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         pc_en;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock (clock),
        .reset (reset),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            kill_q   <= 1'b0;
            inst_q   <= 32'd0;
            pc_out_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            kill_q   <= kill_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        pc_en    = 1'b0;
        pc_d     = pc_q;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Request stays in flight; a kill marks its eventual data as stale.
                    pc_en  = 1'b1;
                    pc_d   = align_word(redirect_pc);
                    kill_d = !imem_ack;
                end else if (imem_ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        inst_d   = imem_data;
                        pc_out_d = pc_q;
                        state_d  = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_d    = align_word(redirect_pc);
                    state_d = ST_FETCH;
                end else if (except) begin
                    state_d = ST_HALT;
                end else if (inst_ready) begin
                    pc_en   = 1'b1;
                    pc_d    = pc_q + c_PC_STEP;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == ST_VALID);
    assign halted     = (state_q == ST_HALT);
    assign inst       = inst_q;
    assign pc_out     = pc_out_q;
    assign opcode     = inst_q[c_OPCODE_MSB:c_OPCODE_LSB];
    assign rs         = inst_q[c_RS_MSB:c_RS_LSB];
    assign rt         = inst_q[c_RT_MSB:c_RT_LSB];
    assign rd         = inst_q[c_RD_MSB:c_RD_LSB];
    assign imm        = inst_q[c_IMM_MSB:c_IMM_LSB];
    assign funct      = inst_q[c_FUNCT_MSB:c_FUNCT_LSB];

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch.sv
// ============================================================================
// Module   : tb_mips_fetch
// Brief    : Directed bench for mips_fetch; two instances (default and
//            top-of-memory RESET_PC) share stimulus and a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_fetch;

    localparam logic [31:0] c_RPC0 = 32'h0040_0000;
    localparam logic [31:0] c_RPC1 = 32'hFFFF_FFFC;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_ready = 1'b0;
    logic        except = 1'b0;

    logic        req0, vld0, hlt0, req1, vld1, hlt1;
    logic [31:0] addr0, inst0, pco0, addr1, inst1, pco1;
    logic [5:0]  op0, fn0, op1, fn1;
    logic [4:0]  rs0, rt0, rd0, rs1, rt1, rd1;
    logic [15:0] imm0, imm1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mips_fetch #(.RESET_PC(c_RPC0)) dut (
        .clock(clock), .reset(reset), .imem_req(req0), .imem_addr(addr0),
        .imem_ack(imem_ack), .imem_data(imem_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_ready(inst_ready), .except(except),
        .inst_valid(vld0), .inst(inst0), .pc_out(pco0), .opcode(op0), .funct(fn0),
        .rs(rs0), .rt(rt0), .rd(rd0), .imm(imm0), .halted(hlt0)
    );

    mips_fetch #(.RESET_PC(c_RPC1)) dut_w (
        .clock(clock), .reset(reset), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_data(imem_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_ready(inst_ready), .except(except),
        .inst_valid(vld1), .inst(inst1), .pc_out(pco1), .opcode(op1), .funct(fn1),
        .rs(rs1), .rt(rt1), .rd(rd1), .imm(imm1), .halted(hlt1)
    );

    // Abstract view of the stage: what it is doing, where it fetches, what it holds.
    typedef struct packed {
        logic        fetching;
        logic        holding;
        logic        stopped;
        logic        stale;
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] word_pc;
    } mdl_t;

    mdl_t m0, m1;
    logic armed = 1'b0;

    function automatic mdl_t step(input mdl_t s, input logic [31:0] rpc);
        mdl_t n = s;
        if (!reset) begin
            n = '0;
            n.fetching = 1'b1;
            n.pc       = rpc;
        end else if (s.holding) begin
            if (redirect_valid) begin
                n.holding  = 1'b0;
                n.fetching = 1'b1;
                n.pc       = {redirect_pc[31:2], 2'b00};
            end else if (except) begin
                n.holding = 1'b0;
                n.stopped = 1'b1;
            end else if (inst_ready) begin
                n.holding  = 1'b0;
                n.fetching = 1'b1;
                n.pc       = s.pc + 32'd4;
            end
        end else if (s.fetching) begin
            if (redirect_valid) begin
                n.pc    = {redirect_pc[31:2], 2'b00};
                n.stale = !imem_ack;
            end else if (imem_ack && s.stale) begin
                n.stale = 1'b0;
            end else if (imem_ack) begin
                n.fetching = 1'b0;
                n.holding  = 1'b1;
                n.word     = imem_data;
                n.word_pc  = s.pc;
            end
        end
        return n;
    endfunction

    always @(posedge clock) begin
        m0 <= step(m0, c_RPC0);
        m1 <= step(m1, c_RPC1);
        if (!reset) armed <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic req, input logic [31:0] addr,
                       input logic vld, input logic hlt, input logic [31:0] iw, input logic [31:0] pco,
                       input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s_rs,
                       input logic [4:0] s_rt, input logic [4:0] s_rd, input logic [15:0] im);
        chk({tag, ".imem_req"},   {31'd0, req}, {31'd0, m.fetching});
        chk({tag, ".imem_addr"},  addr, m.pc);
        chk({tag, ".inst_valid"}, {31'd0, vld}, {31'd0, m.holding});
        chk({tag, ".halted"},     {31'd0, hlt}, {31'd0, m.stopped});
        chk({tag, ".inst"},       iw, m.word);
        chk({tag, ".pc_out"},     pco, m.word_pc);
        chk({tag, ".fields"}, {op, fn, s_rs, s_rt, s_rd, 5'd0},
            {m.word[31:26], m.word[5:0], m.word[25:21], m.word[20:16], m.word[15:11], 5'd0});
        chk({tag, ".imm"}, {16'd0, im}, {16'd0, m.word[15:0]});
    endtask

    always @(negedge clock) begin
        if (armed) begin
            cmp("d0", m0, req0, addr0, vld0, hlt0, inst0, pco0, op0, fn0, rs0, rt0, rd0, imm0);
            cmp("d1", m1, req1, addr1, vld1, hlt1, inst1, pco1, op1, fn1, rs1, rt1, rd1, imm1);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic ack_word(input logic [31:0] w);
        imem_ack  = 1'b1;
        imem_data = w;
        tick();
        imem_ack  = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst.addr0", addr0, 32'h0040_0000);
        chk("rst.addr1", addr1, 32'hFFFF_FFFC);
        chk("rst.req_valid", {30'd0, req0, vld0}, 32'd2);
        chk("rst.pc_out", pco0, 32'd0);

        // First fetch: two idle cycles, then ack.
        reset = 1'b1;
        tick(2);
        ack_word(32'h0123_4820);
        chk("f1.valid", {31'd0, vld0}, 32'd1);
        chk("f1.fields", {26'd0, op0}, 32'd0);
        chk("f1.funct", {26'd0, fn0}, 32'h20);
        chk("f1.rs_rt_rd", {17'd0, rs0, rt0, rd0}, {17'd0, 5'd9, 5'd3, 5'd9});
        chk("f1.pc_out1", pco1, 32'hFFFF_FFFC);

        // Decode stall then accept.
        tick(3);
        chk("stall.inst", inst0, 32'h0123_4820);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("adv.addr0", addr0, 32'h0040_0004);
        chk("wrap.addr1", addr1, 32'h0000_0000);

        // Redirect while the request is outstanding; its data must be dropped.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        tick();
        ack_word(32'hDEAD_BEEF);
        chk("kill.valid", {31'd0, vld0}, 32'd0);
        chk("kill.addr", addr0, 32'h0040_0100);
        tick(2);
        ack_word(32'h8C43_0004);
        chk("kill.new_pc", pco0, 32'h0040_0100);
        chk("kill.new_inst", inst0, 32'h8C43_0004);

        // Redirect coinciding with ack.
        inst_ready = 1'b1;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        ack_word(32'h1111_1111);
        redirect_valid = 1'b0;
        chk("same.valid", {31'd0, vld0}, 32'd0);
        chk("same.addr", addr0, 32'h0040_0200);
        ack_word(32'h0000_0000);
        chk("same.pc_out", pco0, 32'h0040_0200);

        // Redirect in VALID beats except and inst_ready.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0300;
        except         = 1'b1;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        except         = 1'b0;
        inst_ready     = 1'b0;
        chk("prio.addr", addr0, 32'h0040_0300);
        chk("prio.halted", {31'd0, hlt0}, 32'd0);
        ack_word(32'h0000_000C);

        // Exception halts; redirects and acks ignored afterwards.
        except     = 1'b1;
        inst_ready = 1'b1;
        tick();
        except     = 1'b0;
        inst_ready = 1'b0;
        chk("halt.flag", {31'd0, hlt0}, 32'd1);
        chk("halt.pc_out", pco0, 32'h0040_0300);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0050_0000;
        ack_word(32'h2222_2222);
        redirect_valid = 1'b0;
        tick(2);
        chk("halt.req", {31'd0, req0}, 32'd0);
        chk("halt.addr", addr0, 32'h0040_0300);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rerst.addr", addr0, 32'h0040_0000);
        chk("rerst.req", {31'd0, req0}, 32'd1);

        // Reset in the same cycle as an ack.
        tick(2);
        reset = 1'b0;
        ack_word(32'h3333_3333);
        reset = 1'b1;
        chk("rack.valid", {30'd0, vld0, vld1}, 32'd0);
        chk("rack.addr1", addr1, 32'hFFFF_FFFC);
        tick();
        chk("rack.valid2", {30'd0, vld0, vld1}, 32'd0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_fetch.md
MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the first instruction byte address after reset.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset (0 = reset), sampled on the rising clock edge.
REQ-004 imem_req  output  1  SHALL be the instruction memory read request.
REQ-005 imem_addr  output  32  SHALL be the byte address of the requested word, with bits [1:0] always 0.
REQ-006 imem_ack  input  1  SHALL indicate that imem_data is valid for the outstanding request this cycle.
REQ-007 imem_data  input  32  SHALL be the returned instruction word.
REQ-008 redirect_valid  input  1  SHALL request a fetch restart at redirect_pc (branch/jump).
REQ-009 redirect_pc  input  32  SHALL be the restart byte address.
REQ-010 inst_ready  input  1  SHALL indicate that the decode stage accepts the presented instruction this cycle.
REQ-011 except  input  1  SHALL be the decoder's illegal-instruction flag for the presented instruction.
REQ-012 inst_valid  output  1  SHALL indicate that inst, pc_out and the field outputs are valid.
REQ-013 inst / pc_out  output  32 each  SHALL be the held instruction word and its address.
REQ-014 opcode, funct  output  6 each  SHALL be inst[31:26] and inst[5:0]; rs, rt, rd  output  5 each  SHALL be inst[25:21], [20:16], [15:11]; imm  output  16  SHALL be inst[15:0].
REQ-015 halted  output  1  SHALL indicate that fetch has stopped on an exception.

Function
REQ-016 The FSM SHALL have the states FETCH (imem_req=1, waiting for ack), VALID (instruction held, inst_valid=1) and HALT (no requests, halted=1).
REQ-017 In FETCH with imem_ack=1 and no kill pending, imem_data SHALL be captured into inst and the FSM SHALL enter VALID on the next cycle (one-cycle latency from ack to inst_valid).
REQ-018 imem_addr SHALL equal the PC register and SHALL remain stable while imem_req=1 and no ack has arrived.
REQ-019 In VALID with inst_valid=1 and inst_ready=1 and except=0, PC SHALL become PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and the FSM SHALL return to FETCH.
REQ-020 In VALID with inst_ready=0, inst, pc_out and the fields SHALL hold unchanged.
REQ-021 In VALID with except=1, the FSM SHALL enter HALT regardless of inst_ready; PC SHALL NOT advance, and inst and pc_out SHALL retain the faulting instruction.
REQ-022 In VALID, redirect_valid=1 SHALL take priority over inst_ready and except: the held instruction SHALL be dropped, PC SHALL become {redirect_pc[31:2],2'b00}, and the FSM SHALL go to FETCH.
REQ-023 In FETCH, redirect_valid=1 SHALL load the redirect PC and set a kill flag; the in-flight request SHALL NOT be abandoned, and its ack data SHALL be discarded, after which a new request SHALL be issued at the redirect PC.
REQ-024 Redirect and ack arriving in the same FETCH cycle SHALL discard the data, SHALL NOT set the kill flag, and SHALL make the next cycle request the redirect PC.
REQ-025 imem_ack SHALL be ignored outside FETCH.
REQ-026 HALT SHALL be exited only by reset, and redirect_valid SHALL be ignored in HALT.
REQ-027 inst_valid SHALL be 1 only in VALID, and imem_req SHALL be 1 only in FETCH.

Reset
REQ-028 While reset=0 at a clock edge, the next state SHALL be: FSM=FETCH, PC=RESET_PC, kill=0, inst=0, pc_out=0, inst_valid=0, halted=0, imem_req=1, imem_addr=RESET_PC.
REQ-029 Reset SHALL override every other input in the same cycle, including imem_ack arriving mid-request, which SHALL be dropped.

Structure
REQ-030 The state encodings and the instruction field bit positions SHALL be defined in the shared MIPS define header alongside the opcode/funct constants; RESET_PC SHALL remain a module parameter.
REQ-031 The PC SHALL be held in one sub-module, pc_reg (32-bit, synchronous active-low reset to RESET_PC, with an enable), instantiated once.

Verification
REQ-032 Release reset, ack after 2 cycles with 32'h0123_4820 -> imem_addr=0x0040_0000, inst_valid=1 one cycle after ack, opcode=0, funct=6'h20, rs=9, rt=3, rd=9.
REQ-033 Hold inst_ready=0 for 3 cycles, then 1 -> outputs stable for 3 cycles, then the next imem_addr=0x0040_0004.
REQ-034 Assert redirect_valid with redirect_pc=0x0040_0103 during an outstanding FETCH, then ack 0xDEAD_BEEF -> data discarded, next request at 0x0040_0100, inst_valid stays 0 until that request's ack.
REQ-035 Present an instruction with except=1 and inst_ready=1 -> halted=1, imem_req=0 thereafter, pc_out unchanged, later redirects ignored, reset returns to FETCH at 0x0040_0000.
REQ-036 With RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=0x0000_0000; also assert reset on the same cycle as an ack -> no inst_valid, imem_addr=RESET_PC.
